// File: rtl/dds_phase_mac_multilane.sv
// Purpose: LANES parallel DDS phase words, top OUT_W bits of ((ts + k - offset) * freq) plus left-aligned phase.
// Latency: 4 cycles from input transfer to out_valid when not stalled; one sample per cycle.
// Backpressure: the whole pipe freezes while out_valid && !out_ready; in_ready = !(out_valid && !out_ready).
module dds_phase_mac_multilane #(
    parameter int TIME_W  = 48,
    parameter int FREQ_W  = 48,
    parameter int PHASE_W = 14,
    parameter int OUT_W   = 16,
    parameter int LANES   = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     cfg_valid,
    input  logic [TIME_W-1:0]        cfg_offset,
    input  logic [FREQ_W-1:0]        cfg_freq,
    input  logic [PHASE_W-1:0]       cfg_phase,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [TIME_W-1:0]        timestamp,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*OUT_W-1:0]   out_phase
);
    // Multiplier slicing: 16-bit slices, only slice pairs whose product lands below FREQ_W are built.
    localparam int SL   = 16;
    localparam int NS   = (FREQ_W + SL - 1) / SL;
    localparam int PADW = NS * SL;
    localparam int NP   = NS * (NS + 1) / 2;
    localparam int PPW  = 2 * SL;
    localparam int PSH  = OUT_W - PHASE_W;
    localparam int TSH  = FREQ_W - OUT_W;

    logic                    adv;

    logic [TIME_W-1:0]       act_offset_q, act_offset_d;
    logic [FREQ_W-1:0]       act_freq_q,   act_freq_d;
    logic [PHASE_W-1:0]      act_phase_q,  act_phase_d;

    logic                    s0_vld_q, s0_vld_d;
    logic [FREQ_W-1:0]       s0_diff_q [LANES];
    logic [FREQ_W-1:0]       s0_diff_d [LANES];
    logic [FREQ_W-1:0]       s0_freq_q, s0_freq_d;
    logic [PHASE_W-1:0]      s0_phase_q, s0_phase_d;

    logic                    s1_vld_q, s1_vld_d;
    logic [PPW-1:0]          s1_pp_q [LANES][NP];
    logic [PPW-1:0]          s1_pp_d [LANES][NP];
    logic [PHASE_W-1:0]      s1_phase_q, s1_phase_d;

    logic                    s2_vld_q, s2_vld_d;
    logic [PADW-1:0]         s2_row_q [LANES][NS];
    logic [PADW-1:0]         s2_row_d [LANES][NS];
    logic [PHASE_W-1:0]      s2_phase_q, s2_phase_d;

    logic                    out_vld_q, out_vld_d;
    logic [LANES*OUT_W-1:0]  out_dat_q, out_dat_d;

    // A single advance enable freezes every stage together when the output is blocked.
    assign adv       = !(out_vld_q && !out_ready);
    assign in_ready  = adv;
    assign out_valid = out_vld_q;
    assign out_phase = out_dat_q;

    // Active configuration: written on any edge with cfg_valid, regardless of stall; last write wins.
    always_comb begin
        act_offset_d = act_offset_q;
        act_freq_d   = act_freq_q;
        act_phase_d  = act_phase_q;
        if (cfg_valid) begin
            act_offset_d = cfg_offset;
            act_freq_d   = cfg_freq;
            act_phase_d  = cfg_phase;
        end
    end

    // S0: per-lane time difference, snapshot of the config the sample was accepted under.
    always_comb begin
        logic [TIME_W-1:0] dt;
        dt         = '0;
        s0_vld_d   = s0_vld_q;
        s0_diff_d  = s0_diff_q;
        s0_freq_d  = s0_freq_q;
        s0_phase_d = s0_phase_q;
        if (adv) begin
            s0_vld_d   = in_valid;
            s0_freq_d  = act_freq_q;
            s0_phase_d = act_phase_q;
            for (int k = 0; k < LANES; k++) begin
                dt           = timestamp + TIME_W'(k) - act_offset_q;
                s0_diff_d[k] = FREQ_W'(dt);
            end
        end
    end

    // S1: 16x16 partial products, lower-triangle slice pairs only (higher ones wrap out of the accumulator).
    always_comb begin
        logic [PADW-1:0] dpad;
        logic [PADW-1:0] fpad;
        int              p;
        dpad       = '0;
        fpad       = PADW'(s0_freq_q);
        p          = 0;
        s1_vld_d   = s1_vld_q;
        s1_pp_d    = s1_pp_q;
        s1_phase_d = s1_phase_q;
        if (adv) begin
            s1_vld_d   = s0_vld_q;
            s1_phase_d = s0_phase_q;
            for (int l = 0; l < LANES; l++) begin
                dpad = PADW'(s0_diff_q[l]);
                p    = 0;
                for (int i = 0; i < NS; i++) begin
                    for (int j = 0; j < NS; j++) begin
                        if (i + j < NS) begin
                            s1_pp_d[l][p] = PPW'(dpad[SL*i +: SL]) * PPW'(fpad[SL*j +: SL]);
                            p = p + 1;
                        end
                    end
                end
            end
        end
    end

    // S2: reduce partial products into one shifted row sum per d-slice.
    always_comb begin
        logic [PADW-1:0] row;
        int              p;
        row        = '0;
        p          = 0;
        s2_vld_d   = s2_vld_q;
        s2_row_d   = s2_row_q;
        s2_phase_d = s2_phase_q;
        if (adv) begin
            s2_vld_d   = s1_vld_q;
            s2_phase_d = s1_phase_q;
            for (int l = 0; l < LANES; l++) begin
                p = 0;
                for (int i = 0; i < NS; i++) begin
                    row = '0;
                    for (int j = 0; j < NS; j++) begin
                        if (i + j < NS) begin
                            row = row + (PADW'(s1_pp_q[l][p]) << (SL * (i + j)));
                            p = p + 1;
                        end
                    end
                    s2_row_d[l][i] = row;
                end
            end
        end
    end

    // S3: final sum mod 2^FREQ_W, take the top OUT_W bits, add the left-aligned phase offset.
    always_comb begin
        logic [PADW-1:0]   acc;
        logic [FREQ_W-1:0] accf;
        logic [OUT_W-1:0]  ph;
        acc       = '0;
        accf      = '0;
        ph        = OUT_W'(s2_phase_q) << PSH;
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        if (adv) begin
            out_vld_d = s2_vld_q;
            for (int l = 0; l < LANES; l++) begin
                acc = '0;
                for (int i = 0; i < NS; i++) begin
                    acc = acc + s2_row_q[l][i];
                end
                accf = FREQ_W'(acc);
                out_dat_d[l*OUT_W +: OUT_W] = OUT_W'(accf >> TSH) + ph;
            end
        end
    end

    // State registers; reset discards in-flight samples and clears output and config at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            act_offset_q <= '0;
            act_freq_q   <= '0;
            act_phase_q  <= '0;
            s0_vld_q     <= 1'b0;
            s0_diff_q    <= '{default: '0};
            s0_freq_q    <= '0;
            s0_phase_q   <= '0;
            s1_vld_q     <= 1'b0;
            s1_pp_q      <= '{default: '0};
            s1_phase_q   <= '0;
            s2_vld_q     <= 1'b0;
            s2_row_q     <= '{default: '0};
            s2_phase_q   <= '0;
            out_vld_q    <= 1'b0;
            out_dat_q    <= '0;
        end else begin
            act_offset_q <= act_offset_d;
            act_freq_q   <= act_freq_d;
            act_phase_q  <= act_phase_d;
            s0_vld_q     <= s0_vld_d;
            s0_diff_q    <= s0_diff_d;
            s0_freq_q    <= s0_freq_d;
            s0_phase_q   <= s0_phase_d;
            s1_vld_q     <= s1_vld_d;
            s1_pp_q      <= s1_pp_d;
            s1_phase_q   <= s1_phase_d;
            s2_vld_q     <= s2_vld_d;
            s2_row_q     <= s2_row_d;
            s2_phase_q   <= s2_phase_d;
            out_vld_q    <= out_vld_d;
            out_dat_q    <= out_dat_d;
        end
    end

endmodule

// File: tb/tb_dds_phase_mac_multilane.sv
// Bench for dds_phase_mac_multilane with default parameters (48/48/14/16, 4 lanes).
// Driver pushes expected words into a queue on each input transfer; a monitor pops on each output transfer.
// Backpressure phase randomises out_ready and checks that a stalled output holds.
module tb_dds_phase_mac_multilane;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [47:0] cfg_offset = '0;
    logic [47:0] cfg_freq = '0;
    logic [13:0] cfg_phase = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [47:0] timestamp = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_phase;

    logic [63:0] exp_q[$];
    int          n_chk = 0;
    int          n_bad = 0;
    int          n_in = 0;
    int          n_out = 0;
    int          n_flushed = 0;
    bit          rand_rdy = 1'b0;
    logic [47:0] m_off = '0;
    logic [47:0] m_freq = '0;
    logic [13:0] m_phase = '0;

    localparam logic [47:0] F32 = 48'h0001_0000_0000;
    localparam logic [47:0] F33 = 48'h0002_0000_0000;

    dds_phase_mac_multilane dut (
        .clk        (clk),
        .resetn     (resetn),
        .cfg_valid  (cfg_valid),
        .cfg_offset (cfg_offset),
        .cfg_freq   (cfg_freq),
        .cfg_phase  (cfg_phase),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .timestamp  (timestamp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_phase  (out_phase)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    // Reference: plain wide multiply per lane, no slicing.
    function automatic logic [63:0] model(input logic [47:0] ts, input logic [47:0] off,
                                          input logic [47:0] fr, input logic [13:0] ph);
        logic [63:0] r;
        logic [47:0] d;
        logic [95:0] p;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            d = ts + 48'(k) - off;
            p = {48'd0, d} * {48'd0, fr};
            r[k*16 +: 16] = p[47:32] + {ph, 2'b00};
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic set_cfg(input logic [47:0] off, input logic [47:0] fr, input logic [13:0] ph);
        @(negedge clk);
        in_valid   = 1'b0;
        cfg_valid  = 1'b1;
        cfg_offset = off;
        cfg_freq   = fr;
        cfg_phase  = ph;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        m_off     = off;
        m_freq    = fr;
        m_phase   = ph;
    endtask

    // Offer one sample until accepted; optional same-cycle config write (applies from the next sample).
    task automatic send(input logic [47:0] ts, input bit use_exp, input logic [63:0] ev, input bit cv,
                        input logic [47:0] coff, input logic [47:0] cfr, input logic [13:0] cph);
        bit done;
        bit cvl;
        int guard;
        done  = 1'b0;
        cvl   = cv;
        guard = 0;
        while (!done) begin
            @(negedge clk);
            in_valid   = 1'b1;
            timestamp  = ts;
            cfg_valid  = cvl;
            cfg_offset = coff;
            cfg_freq   = cfr;
            cfg_phase  = cph;
            #1;
            if (in_ready) begin
                exp_q.push_back(use_exp ? ev : model(ts, m_off, m_freq, m_phase));
                n_in++;
                done = 1'b1;
            end
            if (cvl) begin
                m_off   = coff;
                m_freq  = cfr;
                m_phase = cph;
                cvl     = 1'b0;
            end
            guard++;
            if (!done && guard >= 1000) begin
                chk("in_ready_timeout", 64'(in_ready), 64'd1);
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        chk(nm, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: drives out_ready, pops/compares on each output transfer, checks stalled outputs hold.
    initial begin
        logic [63:0] e;
        logic [63:0] hold_dat;
        bit          hold_vld;
        hold_vld = 1'b0;
        hold_dat = '0;
        forever begin
            @(negedge clk);
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            #2;
            if (!resetn) begin
                hold_vld = 1'b0;
                continue;
            end
            if (hold_vld) begin
                chk("stall_vld", 64'(out_valid), 64'd1);
                chk("stall_dat", out_phase, hold_dat);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_bad++;
                    $display("FAIL out_spurious: got %h want no output", out_phase);
                end else begin
                    e = exp_q.pop_front();
                    n_out++;
                    chk("out_phase", out_phase, e);
                end
                hold_vld = 1'b0;
            end else if (out_valid) begin
                hold_vld = 1'b1;
                hold_dat = out_phase;
            end else begin
                hold_vld = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r64;
        logic [63:0] ev;
        logic [47:0] ts;
        logic [47:0] off;
        logic [47:0] fr;
        logic [13:0] ph;
        bit          cv;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_phase", out_phase, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Config is zero after reset: every lane is 0
        send(48'd77, 1'b1, 64'h0, 1'b0, '0, '0, '0);
        drain("drain_cfg0");

        // Directed vectors
        set_cfg(48'd0, F32, 14'd0);
        send(48'd5, 1'b1, 64'h0008_0007_0006_0005, 1'b0, '0, '0, '0);
        set_cfg(48'd0, F32, 14'd1);
        send(48'd5, 1'b1, 64'h000C_000B_000A_0009, 1'b0, '0, '0, '0);
        set_cfg(48'd0, F32, 14'h3FFF);
        send(48'd0, 1'b1, 64'hFFFF_FFFE_FFFD_FFFC, 1'b0, '0, '0, '0);
        set_cfg(48'd0, F32, 14'd0);
        send(48'hFFFF, 1'b1, 64'h0002_0001_0000_FFFF, 1'b0, '0, '0, '0);
        set_cfg(48'd1, F32, 14'd0);
        send(48'd0, 1'b1, 64'h0002_0001_0000_FFFF, 1'b0, '0, '0, '0);
        drain("drain_directed");

        // Config ordering: freq 2^33 written in the cycle timestamp 4 is accepted
        set_cfg(48'd0, F32, 14'd0);
        for (int t = 0; t < 10; t++) begin
            ev = '0;
            for (int k = 0; k < 4; k++) begin
                ev[k*16 +: 16] = (t <= 4) ? 16'(t + k) : 16'(2 * (t + k));
            end
            send(48'(t), 1'b1, ev, (t == 4), 48'd0, F33, 14'd0);
        end
        drain("drain_cfg_order");

        // Random stream under 50% backpressure with occasional config writes
        rand_rdy = 1'b1;
        r64 = {$urandom(), $urandom()};
        fr  = r64[47:0];
        r64 = {$urandom(), $urandom()};
        set_cfg(r64[47:0], fr, 14'($urandom()));
        for (int n = 0; n < 1000; n++) begin
            r64 = {$urandom(), $urandom()};
            ts  = r64[47:0];
            r64 = {$urandom(), $urandom()};
            off = r64[47:0];
            r64 = {$urandom(), $urandom()};
            fr  = r64[47:0];
            ph  = 14'($urandom());
            cv  = ($urandom_range(0, 9) == 0);
            send(ts, 1'b0, '0, cv, off, fr, ph);
            if ($urandom_range(0, 7) == 0) @(negedge clk);
        end
        drain("drain_random");
        rand_rdy = 1'b0;

        // Reset mid-stream
        set_cfg(48'd0, F32, 14'd0);
        for (int i = 0; i < 6; i++) begin
            send(48'(100 + i), 1'b0, '0, 1'b0, '0, '0, '0);
        end
        @(negedge clk);
        #1;
        chk("pre_rst_vld", 64'(out_valid), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_vld", 64'(out_valid), 64'd0);
        chk("mid_rst_phase", out_phase, 64'd0);
        n_flushed = n_flushed + exp_q.size();
        exp_q.delete();
        m_off   = '0;
        m_freq  = '0;
        m_phase = '0;
        @(negedge clk);
        #4;
        resetn = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        send(48'd123, 1'b1, 64'h0, 1'b0, '0, '0, '0);
        drain("drain_reset");

        chk("io_count", 64'(n_out), 64'(n_in - n_flushed));
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
